// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the TPU array sequencer.
//   tpu_op_e         host command opcode
//   tpu_seq_state_e  sequencer FSM state
package tpu_pkg;

    localparam int unsigned DIM_DEF  = 8;
    localparam int unsigned KMAX_DEF = 256;

    typedef enum logic [1:0] {
        OP_LOADC,
        OP_COMPUTE,
        OP_DRAIN,
        OP_RSVD
    } tpu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADC,
        S_COMP,
        S_DRAIN
    } tpu_seq_state_e;

endpackage

// File: rtl/tpu_array_seq_if.sv
// Host command channel into the array sequencer.
//   cmd_valid / cmd_ready  handshake, command taken on valid && ready
//   cmd_op                 opcode (tpu_op_e)
//   cmd_k                  inner dimension K, meaningful for OP_COMPUTE only
// master = host side, slave = sequencer side.
interface tpu_array_seq_if
    import tpu_pkg::*;
#(
    parameter int unsigned KW = 9
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    tpu_op_e       cmd_op;
    logic [KW-1:0] cmd_k;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_k,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_k,
        output cmd_ready
    );

endinterface

// File: rtl/tpu_skew_gen.sv
// Row skew generator for the A/B feeders of a DIM x DIM systolic array.
// Row i is fed during steps i .. i+K-1; a 0 tells the feeder to inject zeros.
//   step        current sequence step
//   k           inner dimension K
//   feed_valid  per-row valid, bit i for row i
module tpu_skew_gen #(
    parameter int unsigned DIM = 8,
    parameter int unsigned KW  = 9
) (
    input  logic [KW-1:0]  step,
    input  logic [KW-1:0]  k,
    output logic [DIM-1:0] feed_valid
);

    // One extra bit so i+K never wraps regardless of parameters.
    localparam int unsigned EW = KW + 1;

    always_comb begin
        feed_valid = '0;
        for (int i = 0; i < DIM; i++) begin
            feed_valid[i] = ({1'b0, step} >= EW'(i)) &&
                            ({1'b0, step} < ({1'b0, k} + EW'(i)));
        end
    end

endmodule

// File: rtl/tpu_array_seq.sv
// Sequencer for a DIM x DIM output-stationary systolic array of MAC cells.
// Takes one command at a time (LOAD_C, COMPUTE, DRAIN), drives the array
// enable / write-enable, operand buffer read addresses and row skew valids.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd               command channel (tpu_array_seq_if.slave)
//   stall             downstream not ready: freeze the sequence
//   mac_en, mac_wren  array enable and C shift/load enable
//   a_rd_addr         A buffer read index, b_rd_addr identical
//   feed_valid        per-row feeder valid
//   c_row_sel         C row being loaded/drained
//   busy, done, err   status; done/err are single-cycle pulses
//
// Optional feature macro TPU_SEQ_PERF_EN adds saturating counters
// perf_active (active cycles) and perf_stall (stalled op-state cycles).
module tpu_array_seq
    import tpu_pkg::*;
#(
    parameter  int unsigned DIM  = DIM_DEF,
    parameter  int unsigned KMAX = KMAX_DEF,
    localparam int unsigned KW   = $clog2(KMAX + 2 * DIM),
    localparam int unsigned RW   = $clog2(DIM)
) (
    input  logic           clk,
    input  logic           rst_n,
    tpu_array_seq_if.slave cmd,
    input  logic           stall,
    output logic           mac_en,
    output logic           mac_wren,
    output logic [KW-1:0]  a_rd_addr,
    output logic [KW-1:0]  b_rd_addr,
    output logic [DIM-1:0] feed_valid,
    output logic [RW-1:0]  c_row_sel,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef TPU_SEQ_PERF_EN
    ,
    output logic [31:0]    perf_active,
    output logic [31:0]    perf_stall
`endif
);

    tpu_seq_state_e state_q, state_d;
    logic [KW-1:0]  step_q, step_d;
    logic [KW-1:0]  k_q, k_d;

    logic           cmd_bad;
    logic           active;
    logic [KW-1:0]  last_step;
    logic [DIM-1:0] skew_valid;

    tpu_skew_gen #(
        .DIM (DIM),
        .KW  (KW)
    ) u_skew (
        .step       (step_q),
        .k          (k_q),
        .feed_valid (skew_valid)
    );

    always_comb begin
        cmd_bad = (cmd.cmd_op == OP_RSVD) ||
                  ((cmd.cmd_op == OP_COMPUTE) &&
                   ((cmd.cmd_k == '0) || (cmd.cmd_k > KW'(KMAX))));
    end

    // COMPUTE: last product lands in PE(DIM-1,DIM-1) at step K-1+2(DIM-1).
    always_comb begin
        if (state_q == S_COMP) begin
            last_step = k_q + KW'(2 * DIM - 3);
        end else begin
            last_step = KW'(DIM - 1);
        end
    end

    assign active = (state_q != S_IDLE) && !stall;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            k_q     <= k_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && !cmd_bad) begin
                    step_d = '0;
                    k_d    = cmd.cmd_k;
                    unique case (cmd.cmd_op)
                        OP_LOADC:   state_d = S_LOADC;
                        OP_COMPUTE: state_d = S_COMP;
                        OP_DRAIN:   state_d = S_DRAIN;
                        default:    state_d = S_IDLE;
                    endcase
                end
            end
            S_LOADC, S_COMP, S_DRAIN: begin
                if (!stall) begin
                    if (step_q == last_step) begin
                        state_d = S_IDLE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        cmd.cmd_ready = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        mac_en        = active;
        mac_wren      = active && ((state_q == S_LOADC) || (state_q == S_DRAIN));
        done          = active && (step_q == last_step);
        err           = (state_q == S_IDLE) && cmd.cmd_valid && cmd_bad;
        a_rd_addr     = '0;
        feed_valid    = '0;
        c_row_sel     = '0;
        if (state_q == S_COMP) begin
            feed_valid = skew_valid;
            if (step_q < k_q) begin
                a_rd_addr = step_q;
            end
        end
        if ((state_q == S_LOADC) || (state_q == S_DRAIN)) begin
            c_row_sel = step_q[RW-1:0];
        end
        b_rd_addr = a_rd_addr;
    end

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_active_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_active_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (active && (perf_active_q != '1)) begin
                perf_active_q <= perf_active_q + 32'd1;
            end
            if (busy && stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_active = perf_active_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
